// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the dual-clock FIFO: turns rempty/rinc/rdata into a
// registered valid/ready stream through a 2-entry buffer, and counts delivered words.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [CSIZE-1:0] rd_count,
  output logic [1:0]       dbg_cnt
);

  // Occupancy of the output buffer; buf0 is always the head.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DSIZE-1:0] buf0;
  logic [DSIZE-1:0] buf1;
  logic [DSIZE-1:0] buf0_nxt;
  logic [DSIZE-1:0] buf1_nxt;
  logic             push;
  logic             pop;

  // Handshake: a word transfers on every rclk edge where m_valid && m_ready; once
  // m_valid is high, m_data stays stable until that transfer. rinc depends only on
  // rempty and registered occupancy, so m_ready never reaches the FIFO combinationally.
  assign rinc    = !rempty && (state != S_TWO);
  assign push    = rinc;
  assign m_valid = (state != S_EMPTY);
  assign pop     = m_valid && m_ready;
  assign m_data  = buf0;
  assign dbg_cnt = state;

  always_comb begin
    state_nxt = state;
    buf0_nxt  = buf0;
    buf1_nxt  = buf1;
    case (state)
      S_EMPTY: begin
        if (push) begin
          buf0_nxt  = rdata;
          state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          buf0_nxt = rdata;
        end else if (push) begin
          buf1_nxt  = rdata;
          state_nxt = S_TWO;
        end else if (pop) begin
          // buf0 keeps its stale value; m_valid=0 masks it.
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          buf0_nxt  = buf1;
          state_nxt = S_ONE;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= S_EMPTY;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      state <= state_nxt;
      buf0  <= buf0_nxt;
      buf1  <= buf1_nxt;
    end
  end

  // Wraps silently at 2^CSIZE.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + CSIZE'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a queue-backed FIFO model feeds the DUT and
// each scenario task checks the stream against hand-derived expectations.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty;
  logic [7:0] rdata;
  logic       m_ready = 1'b0;

  logic        rinc, m_valid;
  logic [7:0]  m_data;
  logic [15:0] rd_count;
  logic [1:0]  dbg_cnt;

  logic        rinc4, m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  rd_count4;
  logic [1:0]  dbg_cnt4;

  int checks = 0;
  int errors = 0;

  // FIFO model: memory plus pointers; reads are asynchronous at rd_ptr.
  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] exp_q[$];

  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr[5:0]];

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (rinc) rd_ptr <= rd_ptr + 1;
  end

  fifo_rd_stream #(.DSIZE(8), .CSIZE(16)) u_dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count),
    .dbg_cnt(dbg_cnt)
  );

  fifo_rd_stream #(.DSIZE(8), .CSIZE(4)) u_dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .rd_count(rd_count4),
    .dbg_cnt(dbg_cnt4)
  );

  task automatic step();
    @(negedge rclk);
    #1;
  endtask

  task automatic fifo_push(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    rrst_n  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    step();
    step();
    rrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({rinc, m_valid, m_data, rd_count} !== 26'h0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: rinc=%b m_valid=%b m_data=%h rd_count=%0d, want all 0",
                 i, rinc, m_valid, m_data, rd_count);
      end
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_push(8'(i));
    #1;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      checks++;
      if (rinc !== (k < 8)) begin
        errors++;
        $display("FAIL stream_rinc k=%0d: got %b want %b", k, rinc, (k < 8));
      end
      checks++;
      if (m_valid !== (k >= 1 && k <= 8)) begin
        errors++;
        $display("FAIL stream_valid k=%0d: got %b want %b", k, m_valid, (k >= 1 && k <= 8));
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if (m_data !== 8'(k)) begin
          errors++;
          $display("FAIL stream_data k=%0d: got %h want %h", k, m_data, 8'(k));
        end
      end
      checks++;
      if (rd_count !== 16'((k >= 1) ? k - 1 : 0)) begin
        errors++;
        $display("FAIL stream_count k=%0d: got %0d want %0d", k, rd_count, (k >= 1) ? k - 1 : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    pulses  = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_push(8'hA0 + 8'(i));
    #1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      if (rinc) pulses++;
      if (k >= 1) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
          errors++;
          $display("FAIL bp_hold k=%0d: m_valid=%b m_data=%h want 1/a0", k, m_valid, m_data);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL bp_rinc_pulses: got %0d want 2", pulses);
    end
    checks++;
    if (dbg_cnt !== 2'd2) begin
      errors++;
      $display("FAIL bp_cnt: got %0d want 2", dbg_cnt);
    end
    m_ready = 1'b1;
    #1;
    for (int j = 0; j <= 6; j++) begin
      if (j > 0) step();
      checks++;
      if (j < 6) begin
        if (m_valid !== 1'b1 || m_data !== 8'hA0 + 8'(j) || rd_count !== 16'(8 + j)) begin
          errors++;
          $display("FAIL bp_drain j=%0d: m_valid=%b m_data=%h rd_count=%0d want 1/%h/%0d",
                   j, m_valid, m_data, rd_count, 8'hA0 + 8'(j), 8 + j);
        end
      end else if (m_valid !== 1'b0 || rd_count !== 16'd14) begin
        errors++;
        $display("FAIL bp_done: m_valid=%b rd_count=%0d want 0/14", m_valid, rd_count);
      end
    end
  endtask

  task automatic test_toggle_ready();
    int cyc;
    for (int i = 0; i < 16; i++) begin
      fifo_push(8'h30 + 8'(i));
      exp_q.push_back(8'h30 + 8'(i));
    end
    #1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      m_ready = (cyc % 2 == 0);
      #1;
      if (dbg_cnt == 2'd2) begin
        checks++;
        if (rinc !== 1'b0) begin
          errors++;
          $display("FAIL toggle_rinc_full cyc %0d: rinc=%b want 0", cyc, rinc);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL toggle_data cyc %0d: got %h want %h", cyc, m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL toggle_timeout: %0d words undelivered", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (rd_count !== 16'd30 || rd_count4 !== 4'd14) begin
      errors++;
      $display("FAIL toggle_count: rd_count=%0d rd_count4=%0d want 30/14", rd_count, rd_count4);
    end
    m_ready = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b0 || rd_count !== 16'd30) begin
      errors++;
      $display("FAIL toggle_no_dup: m_valid=%b rd_count=%0d want 0/30", m_valid, rd_count);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    fifo_push(8'h11);
    fifo_push(8'h22);
    fifo_push(8'h33);
    step();
    step();
    checks++;
    if (dbg_cnt !== 2'd2 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: cnt=%0d m_valid=%b want 2/1", dbg_cnt, m_valid);
    end
    #2;
    rrst_n = 1'b0;
    wr_ptr = rd_ptr;
    #1;
    checks++;
    if ({m_valid, rinc, m_data, rd_count, dbg_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL rst_async: m_valid=%b rinc=%b m_data=%h rd_count=%0d cnt=%0d want all 0",
               m_valid, rinc, m_data, rd_count, dbg_cnt);
    end
    step();
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    fifo_push(8'h55);
    #1;
    checks++;
    if (rinc !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_refill: rinc=%b m_valid=%b want 1/0", rinc, m_valid);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h55) begin
      errors++;
      $display("FAIL rst_first: m_valid=%b m_data=%h want 1/55", m_valid, m_data);
    end
    step();
    checks++;
    if (m_valid !== 1'b0 || rd_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_after: m_valid=%b rd_count=%0d want 0/1", m_valid, rd_count);
    end
  endtask

  task automatic test_count_wrap();
    rrst_n = 1'b0;
    #1;
    step();
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) fifo_push(8'h80 + 8'(i));
    #1;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) step();
      if (k >= 1 && k <= 17) begin
        checks++;
        if (m_valid4 !== 1'b1 || m_data4 !== 8'h80 + 8'(k - 1)) begin
          errors++;
          $display("FAIL wrap_data k=%0d: m_valid=%b m_data=%h want 1/%h",
                   k, m_valid4, m_data4, 8'h80 + 8'(k - 1));
        end
      end
      if (k >= 16) begin
        checks++;
        if (rd_count4 !== 4'((k - 1) % 16)) begin
          errors++;
          $display("FAIL wrap_count k=%0d: got %0d want %0d", k, rd_count4, (k - 1) % 16);
        end
      end
    end
    checks++;
    if (rd_count !== 16'd17) begin
      errors++;
      $display("FAIL wrap_wide_count: got %0d want 17", rd_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle_ready();
    test_reset_mid();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
